// File: rtl/button_debouncer_if.sv
// Button debouncer bus: raw pin in, clean level and event pulses out.
// master = button consumer side, slave = debouncer.
interface button_debouncer_if;
    logic btn_raw;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;
    logic long_press_pulse;

    modport master (
        output btn_raw,
        input  btn_level,
        input  press_pulse,
        input  release_pulse,
        input  long_press_pulse
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output press_pulse,
        output release_pulse,
        output long_press_pulse
    );
endinterface

// File: rtl/button_debouncer.sv
// Push-button debouncer: 2-flop sync, debounce FSM, long-press detect.
// Ports: pin3_clk_16mhz, rst (sync, active high), bus (slave modport).
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES   = 160000,
    parameter int LONG_PRESS_CYCLES = 16000000,
    parameter bit ACTIVE_LOW        = 1'b1
) (
    input  logic               pin3_clk_16mhz,
    input  logic               rst,
    button_debouncer_if.slave  bus
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int LW = $clog2(LONG_PRESS_CYCLES + 1);

    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [LW-1:0] LONG_LAST = LW'(LONG_PRESS_CYCLES - 1);
    localparam logic [LW-1:0] LONG_SAT  = LW'(LONG_PRESS_CYCLES);

    // Raw pin level that means "released".
    localparam logic REL_RAW = ACTIVE_LOW ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        S_RELEASED,
        S_PRESS_WAIT,
        S_PRESSED,
        S_RELEASE_WAIT
    } state_t;

    logic            r_sync1;
    logic            r_sync2;
    state_t          r_state;
    logic [DW-1:0]   r_cnt;
    logic [LW-1:0]   r_lcnt;
    logic            r_level;
    logic            r_press;
    logic            r_release;
    logic            r_long;

    logic            w_p;
    logic            w_long_run;
    state_t          w_state_nxt;
    logic [DW-1:0]   w_cnt_nxt;
    logic [LW-1:0]   w_lcnt_nxt;
    logic            w_level_nxt;
    logic            w_press_nxt;
    logic            w_release_nxt;
    logic            w_long_nxt;

    always_ff @(posedge pin3_clk_16mhz) begin
        if (rst) begin
            r_sync1 <= REL_RAW;
            r_sync2 <= REL_RAW;
        end else begin
            r_sync1 <= bus.btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_p = r_sync2 ^ REL_RAW;

    always_ff @(posedge pin3_clk_16mhz) begin
        if (rst) begin
            r_state   <= S_RELEASED;
            r_cnt     <= '0;
            r_lcnt    <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_long    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_lcnt    <= w_lcnt_nxt;
            r_level   <= w_level_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
            r_long    <= w_long_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_lcnt_nxt    = r_lcnt;
        w_level_nxt   = r_level;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        w_long_nxt    = 1'b0;
        w_long_run    = 1'b0;

        unique case (r_state)
            S_RELEASED: begin
                if (w_p) begin
                    w_state_nxt = S_PRESS_WAIT;
                    w_cnt_nxt   = DW'(1);
                end else begin
                    w_cnt_nxt   = '0;
                end
            end
            S_PRESS_WAIT: begin
                if (!w_p) begin
                    w_state_nxt = S_RELEASED;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == DB_LAST) begin
                    w_state_nxt = S_PRESSED;
                    w_cnt_nxt   = '0;
                    w_level_nxt = 1'b1;
                    w_press_nxt = 1'b1;
                    w_lcnt_nxt  = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + DW'(1);
                end
            end
            S_PRESSED: begin
                w_long_run = 1'b1;
                if (!w_p) begin
                    w_state_nxt = S_RELEASE_WAIT;
                    w_cnt_nxt   = DW'(1);
                end else begin
                    w_cnt_nxt   = '0;
                end
            end
            S_RELEASE_WAIT: begin
                w_long_run = 1'b1;
                if (w_p) begin
                    w_state_nxt = S_PRESSED;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == DB_LAST) begin
                    w_state_nxt   = S_RELEASED;
                    w_cnt_nxt     = '0;
                    w_level_nxt   = 1'b0;
                    w_release_nxt = 1'b1;
                end else begin
                    w_cnt_nxt     = r_cnt + DW'(1);
                end
            end
            default: begin
                w_state_nxt = S_RELEASED;
                w_cnt_nxt   = '0;
            end
        endcase

        // Release wins the edge so pulses stay mutually exclusive;
        // the long counter saturates one past its firing value.
        if (w_long_run && !w_release_nxt) begin
            if (r_lcnt == LONG_LAST) begin
                w_long_nxt = 1'b1;
                w_lcnt_nxt = LONG_SAT;
            end else if (r_lcnt != LONG_SAT) begin
                w_lcnt_nxt = r_lcnt + LW'(1);
            end
        end
    end

    always_comb begin
        bus.btn_level        = r_level;
        bus.press_pulse      = r_press;
        bus.release_pulse    = r_release;
        bus.long_press_pulse = r_long;
    end

endmodule
